// File: rtl/psx_pkg.sv
// PSX pad protocol constants, FSM state encoding and the reply-byte map.
// Latency: none (declarations and a pure combinational helper only).
// Backpressure: none; the console clock paces everything that uses this package.
package psx_pkg;

   localparam logic [7:0] PSX_CMD_START  = 8'h01;
   localparam logic [7:0] PSX_CMD_POLL   = 8'h42;
   localparam logic [7:0] PSX_ID_DIGITAL = 8'h41;
   localparam logic [7:0] PSX_ID_ANALOG  = 8'h73;
   localparam logic [7:0] PSX_READY      = 8'h5A;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SHIFT   = 3'd1,
      ST_ACK_DLY = 3'd2,
      ST_ACK_LO  = 3'd3,
      ST_IGNORE  = 3'd4,
      ST_DONE    = 3'd5
   } psx_state_e;

   // Reply byte for a given frame index, taken from the latched snapshot.
   function automatic logic [7:0] psx_reply_byte(input logic [3:0]  idx,
                                                 input logic        analog,
                                                 input logic [15:0] btn,
                                                 input logic [31:0] stick);
      logic [7:0] r;
      r = 8'hFF;
      case (idx)
         4'd0:    r = 8'hFF;
         4'd1:    r = analog ? PSX_ID_ANALOG : PSX_ID_DIGITAL;
         4'd2:    r = PSX_READY;
         4'd3:    r = btn[7:0];
         4'd4:    r = btn[15:8];
         4'd5:    r = stick[31:24];
         4'd6:    r = stick[23:16];
         4'd7:    r = stick[15:8];
         4'd8:    r = stick[7:0];
         default: r = 8'hFF;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/psx_sync_edge.sv
// Two-flop synchroniser for one asynchronous bus line plus rise/fall pulses.
// Latency: synced level after 2 sample_clk edges; one-cycle edge pulses in that same cycle.
// Backpressure: none; free-running, it samples every cycle.
module psx_sync_edge (
   input  logic sample_clk,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic s1_q;
   logic s2_q;
   logic prev_q;

   // Deliberately not reset: after a mid-frame reset a still-low att must not
   // look like a fresh falling edge.
   always_ff @(posedge sample_clk) begin
      s1_q   <= din;
      s2_q   <= s1_q;
      prev_q <= s2_q;
   end

   assign dout = s2_q;
   assign rise = s2_q & ~prev_q;
   assign fall = ~s2_q & prev_q;

endmodule

// File: rtl/psx_controller.sv
// PSX pad emulator: answers console polls on psx_data and acknowledges bytes on psx_ack.
// Latency: outputs move on the 3rd sample_clk edge after a bus edge; ack follows ACK_DELAY later.
// Backpressure: none; the console owns the bit clock and the pad only paces bytes with ack.
module psx_controller
   import psx_pkg::*;
#(
   parameter int unsigned ANALOG    = 1,
   parameter int unsigned ACK_DELAY = 16,
   parameter int unsigned ACK_WIDTH = 8
) (
   input  logic        sample_clk,
   input  logic        rst_n,
   input  logic        psx_att,
   input  logic        psx_clk,
   input  logic        psx_cmd,
   input  logic [15:0] button_state,
   input  logic [31:0] stick_state,
   output logic        psx_data,
   output logic        psx_ack,
   output logic        active
);

   localparam logic       IS_ANALOG = (ANALOG != 0);
   localparam logic [3:0] LAST_IDX  = IS_ANALOG ? 4'd8 : 4'd4;
   localparam logic [7:0] DLY_LAST  = 8'(ACK_DELAY - 1);
   localparam logic [7:0] WID_LAST  = 8'(ACK_WIDTH - 1);

   logic att_rise, att_fall, clk_rise, clk_fall, cmd_s;
   logic att_s_unused, clk_s_unused, cmd_rise_unused, cmd_fall_unused;

   psx_sync_edge u_sync_att (.sample_clk(sample_clk), .din(psx_att), .dout(att_s_unused),
                             .rise(att_rise), .fall(att_fall));
   psx_sync_edge u_sync_clk (.sample_clk(sample_clk), .din(psx_clk), .dout(clk_s_unused),
                             .rise(clk_rise), .fall(clk_fall));
   psx_sync_edge u_sync_cmd (.sample_clk(sample_clk), .din(psx_cmd), .dout(cmd_s),
                             .rise(cmd_rise_unused), .fall(cmd_fall_unused));

   psx_state_e  state_q, state_d;
   logic [3:0]  byte_idx_q, byte_idx_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  tx_q, tx_d;
   logic [6:0]  rx_q, rx_d;       // first 7 bits; the 8th arrives with the completing edge
   logic [15:0] btn_q, btn_d;
   logic [31:0] stick_q, stick_d;
   logic        data_q, data_d;
   logic        ack_q, ack_d;
   logic        active_q, active_d;
   logic [7:0]  rx_next;

   assign rx_next = {cmd_s, rx_q};

   // Next-state logic: att rise aborts everything, otherwise run the frame FSM.
   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      bit_cnt_d  = bit_cnt_q;
      cnt_d      = cnt_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      btn_d      = btn_q;
      stick_d    = stick_q;
      data_d     = data_q;
      ack_d      = ack_q;
      active_d   = active_q;

      if (att_rise) begin
         state_d    = ST_IDLE;
         byte_idx_d = 4'd0;
         bit_cnt_d  = 3'd0;
         cnt_d      = 8'd0;
         data_d     = 1'b1;
         ack_d      = 1'b1;
         active_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (att_fall) begin
                  state_d    = ST_SHIFT;
                  active_d   = 1'b1;
                  byte_idx_d = 4'd0;
                  bit_cnt_d  = 3'd0;
                  btn_d      = button_state;
                  stick_d    = stick_state;
                  tx_d       = psx_reply_byte(4'd0, IS_ANALOG, button_state, stick_state);
               end
            end
            ST_SHIFT: begin
               if (clk_fall) begin
                  data_d = tx_q[0];
                  tx_d   = {1'b1, tx_q[7:1]};
               end else if (clk_rise) begin
                  rx_d      = rx_next[7:1];
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if ((byte_idx_q == 4'd0 && rx_next != PSX_CMD_START) ||
                         (byte_idx_q == 4'd1 && rx_next != PSX_CMD_POLL)) begin
                        state_d  = ST_IGNORE;
                        data_d   = 1'b1;
                        active_d = 1'b0;
                     end else if (byte_idx_q == LAST_IDX) begin
                        state_d  = ST_DONE;
                        data_d   = 1'b1;
                        active_d = 1'b0;
                     end else begin
                        state_d = ST_ACK_DLY;
                        cnt_d   = 8'd0;
                     end
                  end
               end
            end
            ST_ACK_DLY: begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == DLY_LAST) begin
                  state_d = ST_ACK_LO;
                  ack_d   = 1'b0;
                  cnt_d   = 8'd0;
               end
            end
            ST_ACK_LO: begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == WID_LAST) begin
                  state_d    = ST_SHIFT;
                  ack_d      = 1'b1;
                  cnt_d      = 8'd0;
                  byte_idx_d = byte_idx_q + 4'd1;
                  tx_d       = psx_reply_byte(byte_idx_q + 4'd1, IS_ANALOG, btn_q, stick_q);
               end
            end
            default: begin
               data_d   = 1'b1;
               ack_d    = 1'b1;
               active_d = 1'b0;
            end
         endcase
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge sample_clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         byte_idx_q <= 4'd0;
         bit_cnt_q  <= 3'd0;
         cnt_q      <= 8'd0;
         tx_q       <= 8'hFF;
         rx_q       <= 7'd0;
         btn_q      <= 16'hFFFF;
         stick_q    <= 32'h80808080;
         data_q     <= 1'b1;
         ack_q      <= 1'b1;
         active_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         bit_cnt_q  <= bit_cnt_d;
         cnt_q      <= cnt_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         btn_q      <= btn_d;
         stick_q    <= stick_d;
         data_q     <= data_d;
         ack_q      <= ack_d;
         active_q   <= active_d;
      end
   end

   assign psx_data = data_q;
   assign psx_ack  = ack_q;
   assign active   = active_q;

endmodule

// File: tb/tb_psx_controller.sv
// Directed bench: an analog and a digital pad share one emulated console bus.
// Latency: bits sampled 6 cycles after each psx_clk fall; 40-cycle gap between bytes.
// Backpressure: the console waits a fixed gap per byte; acks are counted by monitors.
module tb_psx_controller;

   localparam int ACK_W = 8;
   localparam int HALF  = 6;
   localparam int GAP   = 40;

   logic        sample_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        psx_att = 1'b1;
   logic        psx_clk = 1'b1;
   logic        psx_cmd = 1'b1;
   logic [15:0] button_state = 16'hFFFF;
   logic [31:0] stick_state = 32'h80808080;
   logic        psx_data_a, psx_ack_a, active_a;
   logic        psx_data_d, psx_ack_d, active_d;

   always #5 sample_clk = ~sample_clk;

   psx_controller #(.ANALOG(1), .ACK_DELAY(16), .ACK_WIDTH(ACK_W)) u_ana (
      .sample_clk(sample_clk), .rst_n(rst_n), .psx_att(psx_att), .psx_clk(psx_clk),
      .psx_cmd(psx_cmd), .button_state(button_state), .stick_state(stick_state),
      .psx_data(psx_data_a), .psx_ack(psx_ack_a), .active(active_a));

   psx_controller #(.ANALOG(0), .ACK_DELAY(16), .ACK_WIDTH(ACK_W)) u_dig (
      .sample_clk(sample_clk), .rst_n(rst_n), .psx_att(psx_att), .psx_clk(psx_clk),
      .psx_cmd(psx_cmd), .button_state(button_state), .stick_state(stick_state),
      .psx_data(psx_data_d), .psx_ack(psx_ack_d), .active(active_d));

   int total = 0;
   int bad   = 0;

   // Ack monitors: count pulses and pulses whose low time is not ACK_W cycles.
   int   ack_cnt_a = 0, ack_len_a = 0, ack_wbad_a = 0;
   int   ack_cnt_d = 0, ack_len_d = 0, ack_wbad_d = 0;
   logic ack_prev_a = 1'b1, ack_prev_d = 1'b1;

   always @(negedge sample_clk) begin
      if (ack_prev_a && !psx_ack_a) ack_cnt_a++;
      if (!psx_ack_a) ack_len_a++;
      else begin
         if (!ack_prev_a && ack_len_a != ACK_W) ack_wbad_a++;
         ack_len_a = 0;
      end
      ack_prev_a = psx_ack_a;
   end

   always @(negedge sample_clk) begin
      if (ack_prev_d && !psx_ack_d) ack_cnt_d++;
      if (!psx_ack_d) ack_len_d++;
      else begin
         if (!ack_prev_d && ack_len_d != ACK_W) ack_wbad_d++;
         ack_len_d = 0;
      end
      ack_prev_d = psx_ack_d;
   end

   logic [7:0] cmd_tbl [9];
   logic [7:0] rep_a [9];
   logic [7:0] rep_d [9];
   logic [7:0] exp_a [9];
   logic [7:0] exp_d [9];
   logic       act_a [9];
   logic       act_d [9];

   task automatic tick(input int n);
      repeat (n) @(posedge sample_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] c, input int nbits,
                            output logic [7:0] ra, output logic [7:0] rd);
      ra = 8'hFF;
      rd = 8'hFF;
      for (int i = 0; i < nbits; i++) begin
         psx_clk = 1'b0;
         psx_cmd = c[i];
         tick(HALF);
         ra[i] = psx_data_a;
         rd[i] = psx_data_d;
         psx_clk = 1'b1;
         tick(HALF);
      end
   endtask

   task automatic run_frame(input int nb, input logic chg);
      psx_att = 1'b0;
      tick(10);
      for (int b = 0; b < nb; b++) begin
         send_byte(cmd_tbl[b], 8, rep_a[b], rep_d[b]);
         if (chg && b == 1) begin
            button_state = 16'hFFFF;
            stick_state  = 32'h0;
         end
         tick(GAP);
         act_a[b] = active_a;
         act_d[b] = active_d;
      end
      psx_att = 1'b1;
      tick(10);
   endtask

   task automatic set_poll_cmds();
      cmd_tbl[0] = 8'h01;
      cmd_tbl[1] = 8'h42;
      for (int i = 2; i < 9; i++) cmd_tbl[i] = 8'h00;
   endtask

   task automatic check_replies(input string tag);
      for (int i = 0; i < 9; i++) begin
         total++;
         if (rep_a[i] !== exp_a[i]) begin
            bad++;
            $display("FAIL %s analog byte%0d got=%02h want=%02h", tag, i, rep_a[i], exp_a[i]);
         end
      end
      for (int i = 0; i < 9; i++) begin
         total++;
         if (rep_d[i] !== exp_d[i]) begin
            bad++;
            $display("FAIL %s digital byte%0d got=%02h want=%02h", tag, i, rep_d[i], exp_d[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(5);
      total++; if (psx_data_a !== 1'b1) begin bad++; $display("FAIL reset data_a got=%b want=1", psx_data_a); end
      total++; if (psx_ack_a !== 1'b1) begin bad++; $display("FAIL reset ack_a got=%b want=1", psx_ack_a); end
      total++; if (active_a !== 1'b0) begin bad++; $display("FAIL reset active_a got=%b want=0", active_a); end
      total++; if (psx_data_d !== 1'b1) begin bad++; $display("FAIL reset data_d got=%b want=1", psx_data_d); end
      total++; if (psx_ack_d !== 1'b1) begin bad++; $display("FAIL reset ack_d got=%b want=1", psx_ack_d); end
      total++; if (active_d !== 1'b0) begin bad++; $display("FAIL reset active_d got=%b want=0", active_d); end
      rst_n = 1'b1;
      tick(5);
   endtask

   // Full poll: 9-byte analog reply and 5-byte digital reply on the same bus.
   task automatic test_poll();
      int ca, cd, wa, wd;
      button_state = 16'hFFBF;
      stick_state  = 32'h8080FF00;
      set_poll_cmds();
      ca = ack_cnt_a; cd = ack_cnt_d; wa = ack_wbad_a; wd = ack_wbad_d;
      run_frame(9, 1'b0);
      exp_a[0] = 8'hFF; exp_a[1] = 8'h73; exp_a[2] = 8'h5A; exp_a[3] = 8'hBF; exp_a[4] = 8'hFF;
      exp_a[5] = 8'h80; exp_a[6] = 8'h80; exp_a[7] = 8'hFF; exp_a[8] = 8'h00;
      exp_d[0] = 8'hFF; exp_d[1] = 8'h41; exp_d[2] = 8'h5A; exp_d[3] = 8'hBF; exp_d[4] = 8'hFF;
      for (int i = 5; i < 9; i++) exp_d[i] = 8'hFF;
      check_replies("poll");
      total++; if (ack_cnt_a - ca !== 8) begin bad++; $display("FAIL poll acks_a got=%0d want=8", ack_cnt_a - ca); end
      total++; if (ack_cnt_d - cd !== 4) begin bad++; $display("FAIL poll acks_d got=%0d want=4", ack_cnt_d - cd); end
      total++; if (ack_wbad_a - wa !== 0) begin bad++; $display("FAIL poll ackwidth_a bad=%0d want=0", ack_wbad_a - wa); end
      total++; if (ack_wbad_d - wd !== 0) begin bad++; $display("FAIL poll ackwidth_d bad=%0d want=0", ack_wbad_d - wd); end
      total++; if (act_d[3] !== 1'b1) begin bad++; $display("FAIL poll active_d_b3 got=%b want=1", act_d[3]); end
      total++; if (act_d[4] !== 1'b0) begin bad++; $display("FAIL poll active_d_b4 got=%b want=0", act_d[4]); end
      total++; if (act_a[7] !== 1'b1) begin bad++; $display("FAIL poll active_a_b7 got=%b want=1", act_a[7]); end
      total++; if (act_a[8] !== 1'b0) begin bad++; $display("FAIL poll active_a_b8 got=%b want=0", act_a[8]); end
   endtask

   // Memory-card address byte: the pad must stay silent for the whole frame.
   task automatic test_memcard();
      int ca;
      cmd_tbl[0] = 8'h81; cmd_tbl[1] = 8'h42; cmd_tbl[2] = 8'h00;
      ca = ack_cnt_a + ack_cnt_d;
      run_frame(3, 1'b0);
      for (int i = 1; i < 3; i++) begin
         total++;
         if (rep_a[i] !== 8'hFF || rep_d[i] !== 8'hFF) begin
            bad++; $display("FAIL memcard byte%0d got=%02h/%02h want=ff", i, rep_a[i], rep_d[i]);
         end
      end
      total++; if (ack_cnt_a + ack_cnt_d - ca !== 0) begin bad++; $display("FAIL memcard acks got=%0d want=0", ack_cnt_a + ack_cnt_d - ca); end
      total++; if (act_a[0] !== 1'b0 || act_d[0] !== 1'b0) begin bad++; $display("FAIL memcard active got=%b/%b want=0", act_a[0], act_d[0]); end
   endtask

   // Att rises mid-byte, then a normal frame must reply from byte 0.
   task automatic test_abort();
      logic [7:0] ra, rd;
      button_state = 16'hFFBF;
      stick_state  = 32'h8080FF00;
      psx_att = 1'b0;
      tick(10);
      send_byte(8'h01, 8, ra, rd); tick(GAP);
      send_byte(8'h42, 8, ra, rd); tick(GAP);
      send_byte(8'h00, 3, ra, rd);
      total++; if (psx_data_a !== 1'b0) begin bad++; $display("FAIL abort pre_data got=%b want=0", psx_data_a); end
      psx_att = 1'b1;
      tick(3);
      total++; if (psx_data_a !== 1'b1 || psx_data_d !== 1'b1) begin bad++; $display("FAIL abort data got=%b/%b want=1", psx_data_a, psx_data_d); end
      total++; if (psx_ack_a !== 1'b1 || psx_ack_d !== 1'b1) begin bad++; $display("FAIL abort ack got=%b/%b want=1", psx_ack_a, psx_ack_d); end
      total++; if (active_a !== 1'b0 || active_d !== 1'b0) begin bad++; $display("FAIL abort active got=%b/%b want=0", active_a, active_d); end
      tick(10);
      set_poll_cmds();
      run_frame(9, 1'b0);
      check_replies("after_abort");
   endtask

   // Buttons and sticks change after byte 1; reply must use the att-fall snapshot.
   task automatic test_snapshot();
      button_state = 16'h0F3C;
      stick_state  = 32'h12345678;
      set_poll_cmds();
      run_frame(9, 1'b1);
      exp_a[0] = 8'hFF; exp_a[1] = 8'h73; exp_a[2] = 8'h5A; exp_a[3] = 8'h3C; exp_a[4] = 8'h0F;
      exp_a[5] = 8'h12; exp_a[6] = 8'h34; exp_a[7] = 8'h56; exp_a[8] = 8'h78;
      exp_d[0] = 8'hFF; exp_d[1] = 8'h41; exp_d[2] = 8'h5A; exp_d[3] = 8'h3C; exp_d[4] = 8'h0F;
      for (int i = 5; i < 9; i++) exp_d[i] = 8'hFF;
      check_replies("snapshot");
   endtask

   // Reset while ack is low: ack releases next edge and the frame is abandoned.
   task automatic test_reset_mid_ack();
      logic [7:0] ra, rd;
      int   ca;
      bit   seen;
      seen = 1'b0;
      psx_att = 1'b0;
      tick(10);
      send_byte(8'h01, 8, ra, rd);
      for (int i = 0; i < 60 && !seen; i++) begin
         tick(1);
         if (psx_ack_a === 1'b0) seen = 1'b1;
      end
      total++; if (!seen) begin bad++; $display("FAIL rstack ack_seen got=0 want=1"); end
      rst_n = 1'b0;
      tick(1);
      total++; if (psx_ack_a !== 1'b1 || psx_ack_d !== 1'b1) begin bad++; $display("FAIL rstack ack got=%b/%b want=1", psx_ack_a, psx_ack_d); end
      rst_n = 1'b1;
      tick(GAP);
      ca = ack_cnt_a + ack_cnt_d;
      send_byte(8'h42, 8, ra, rd); tick(GAP);
      total++; if (ra !== 8'hFF || rd !== 8'hFF) begin bad++; $display("FAIL rstack data got=%02h/%02h want=ff", ra, rd); end
      send_byte(8'h00, 8, ra, rd); tick(GAP);
      total++; if (ack_cnt_a + ack_cnt_d - ca !== 0) begin bad++; $display("FAIL rstack acks got=%0d want=0", ack_cnt_a + ack_cnt_d - ca); end
      total++; if (active_a !== 1'b0 || active_d !== 1'b0) begin bad++; $display("FAIL rstack active got=%b/%b want=0", active_a, active_d); end
      psx_att = 1'b1;
      tick(10);
   endtask

   initial begin
      test_reset();
      test_poll();
      test_memcard();
      test_abort();
      test_snapshot();
      test_reset_mid_ack();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
